// File: rtl/pos_remote_tx_buffer_pkg.sv
// Shared widths and types for the remote transmit buffer.
//   OFFSET_PKT_STRUCT_WIDTH / GLOBAL_CELL_ID_WIDTH / NB_CELL_COUNT_WIDTH : field widths
//   TX_FLIT_WIDTH : one flit = {lifetime, gcid, offset_pkt}
//   txb_state_t   : flush state machine states
package pos_remote_tx_buffer_pkg;
    localparam int OFFSET_PKT_STRUCT_WIDTH = 27;
    localparam int GLOBAL_CELL_ID_WIDTH    = 3;
    localparam int NB_CELL_COUNT_WIDTH     = 5;
    localparam int TX_FLIT_WIDTH = OFFSET_PKT_STRUCT_WIDTH + 3*GLOBAL_CELL_ID_WIDTH
                                 + NB_CELL_COUNT_WIDTH;

    typedef enum logic [1:0] {TXB_IDLE, TXB_DRAIN, TXB_NULL} txb_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with occupancy count.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : write (caller guarantees space, or a same-cycle read)
//   rd_en             : pop the head (caller guarantees count > 0)
//   rd_data           : head entry, valid whenever count > 0
//   count             : occupancy, 0..DEPTH
//   wr_ptr, rd_ptr    : slot indices, exported so callers can keep per-entry side bits
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic [AW-1:0]    wr_ptr,
    output logic [AW-1:0]    rd_ptr
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is read straight from registers, so a write into an empty
    // FIFO is visible at the head on the following cycle.
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/pos_remote_tx_buffer.sv
// Buffers position packets bound for the remote FPGA and presents them as
// one-flit transfers on a valid/ready link, with back pressure to the node
// and end-of-stream marking on flush.
//   clk, rst                      : clock, synchronous active-high reset
//   i_offset_pkt/i_gcid/i_lifetime: packet fields from the ring node
//   i_valid                       : push request
//   i_flush                       : one-cycle pulse closing the current stream
//   i_tx_ready                    : link accepts the flit this cycle
//   o_tx_flit/o_tx_valid/o_tx_last: link side; last qualified by valid
//   o_back_pressure               : registered almost-full to the node
//   o_overflow                    : sticky, a push was dropped
//   o_empty                       : nothing queued and no flush pending
module pos_remote_tx_buffer
    import pos_remote_tx_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  i_gcid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]     i_lifetime,
    input  logic                               i_valid,
    input  logic                               i_flush,
    input  logic                               i_tx_ready,
    output logic [TX_FLIT_WIDTH-1:0]           o_tx_flit,
    output logic                               o_tx_valid,
    output logic                               o_tx_last,
    output logic                               o_back_pressure,
    output logic                               o_overflow,
    output logic                               o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    txb_state_t         state;
    logic [DEPTH-1:0]   last_flags;
    logic [CNT_W-1:0]   count, count_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TX_FLIT_WIDTH-1:0] head;
    logic               fifo_valid, pop, wr_en;

    assign fifo_valid = (count != '0);
    // The null flit is not a FIFO entry, so its acceptance must not pop.
    assign pop        = i_tx_ready & fifo_valid & (state != TXB_NULL);
    assign wr_en      = i_valid & ((count < CNT_W'(DEPTH)) | pop);
    assign count_next = count + CNT_W'(wr_en) - CNT_W'(pop);

    sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(TX_FLIT_WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({i_lifetime, i_gcid, i_offset_pkt}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    assign o_tx_valid = (state == TXB_NULL) | fifo_valid;
    assign o_tx_flit  = (state == TXB_NULL || !fifo_valid) ? '0 : head;
    assign o_tx_last  = (state == TXB_NULL) | (fifo_valid & last_flags[rd_ptr]);
    assign o_empty    = (count == '0) & (state == TXB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= TXB_IDLE;
            last_flags      <= '0;
            o_back_pressure <= 1'b0;
            o_overflow      <= 1'b0;
        end else begin
            o_overflow      <= o_overflow | (i_valid & ~wr_en);
            o_back_pressure <= (count_next >= CNT_W'(DEPTH - AF_MARGIN));

            // Every write sets its own flag; only a flush arriving with
            // the write makes it the stream end.
            if (wr_en) last_flags[wr_ptr] <= i_flush & (state == TXB_IDLE);

            case (state)
                TXB_IDLE: if (i_flush) begin
                    if (wr_en) begin
                        state <= TXB_DRAIN;
                    end else if (count != '0 && !(pop && count == CNT_W'(1))) begin
                        last_flags[wr_ptr - PTR_W'(1)] <= 1'b1;
                        state <= TXB_DRAIN;
                    end else begin
                        // Nothing left to mark (including the only entry
                        // leaving right now): close the stream with a null flit.
                        state <= TXB_NULL;
                    end
                end
                TXB_DRAIN: if (pop && last_flags[rd_ptr]) state <= TXB_IDLE;
                TXB_NULL:  if (i_tx_ready) state <= TXB_IDLE;
                default:   state <= TXB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pos_remote_tx_buffer.sv
module tb_pos_remote_tx_buffer;
    import pos_remote_tx_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_offset_pkt;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  i_gcid;
    logic [NB_CELL_COUNT_WIDTH-1:0]     i_lifetime;
    logic i_valid, i_flush, i_tx_ready;
    logic [TX_FLIT_WIDTH-1:0] o_tx_flit;
    logic o_tx_valid, o_tx_last, o_back_pressure, o_overflow, o_empty;

    int checks = 0;
    int errors = 0;

    pos_remote_tx_buffer #(.DEPTH(16), .AF_MARGIN(4)) dut (
        .clk(clk), .rst(rst),
        .i_offset_pkt(i_offset_pkt), .i_gcid(i_gcid), .i_lifetime(i_lifetime),
        .i_valid(i_valid), .i_flush(i_flush), .i_tx_ready(i_tx_ready),
        .o_tx_flit(o_tx_flit), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last),
        .o_back_pressure(o_back_pressure), .o_overflow(o_overflow), .o_empty(o_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_tx_ready = 1'b0;
        i_offset_pkt = '0; i_gcid = '0; i_lifetime = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_pkt(input int k);
        i_offset_pkt = 27'(k + 256);
        i_gcid       = 9'(k * 7);
        i_lifetime   = 5'(k + 1);
    endtask

    function automatic logic [TX_FLIT_WIDTH-1:0] pkt(input int k);
        return {5'(k + 1), 9'(k * 7), 27'(k + 256)};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_tx_valid, o_tx_last, o_back_pressure, o_overflow, o_empty} !== 5'b00001 ||
            o_tx_flit !== '0) begin
            errors++;
            $display("FAIL reset: v/l/bp/ovf/empty=%b flit=%h, want 00001 flit=0",
                     {o_tx_valid, o_tx_last, o_back_pressure, o_overflow, o_empty}, o_tx_flit);
        end
    endtask

    task automatic test_basic();
        logic [TX_FLIT_WIDTH-1:0] exp [3];
        exp[0] = {5'd4, 9'h000, 27'h0000011};
        exp[1] = {5'd0, 9'h092, 27'h0000022};
        exp[2] = {5'd3, 9'h049, 27'h0000033};
        do_reset();
        i_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_offset_pkt = exp[i][26:0];
            i_gcid       = exp[i][35:27];
            i_lifetime   = exp[i][40:36];
            i_valid      = 1'b1;
            tick();
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_flit !== exp[i] || o_tx_last !== 1'b0) begin
                errors++;
                $display("FAIL basic_flit%0d: v=%b l=%b flit=%h, want v=1 l=0 flit=%h",
                         i, o_tx_valid, o_tx_last, o_tx_flit, exp[i]);
            end
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (o_tx_valid !== 1'b0 || o_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty: v=%b empty=%b, want v=0 empty=1", o_tx_valid, o_empty);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            set_pkt(k); i_valid = 1'b1;
            tick();
            if (k == 10 || k == 11) begin
                checks++;
                if (o_back_pressure !== (k == 11)) begin
                    errors++;
                    $display("FAIL bp_after_push%0d: bp=%b, want %b", k + 1, o_back_pressure, k == 11);
                end
            end
        end
        i_valid = 1'b0;
        checks++;
        if (o_overflow !== 1'b0 || o_back_pressure !== 1'b1 || o_tx_flit !== pkt(0)) begin
            errors++;
            $display("FAIL bp_full: ovf=%b bp=%b flit=%h, want ovf=0 bp=1 flit=%h",
                     o_overflow, o_back_pressure, o_tx_flit, pkt(0));
        end
        set_pkt(16); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b, want 1", o_overflow);
        end
        tick();
        checks++;
        if (o_overflow !== 1'b1 || o_tx_flit !== pkt(0)) begin
            errors++;
            $display("FAIL bp_sticky: ovf=%b flit=%h, want ovf=1 flit=%h", o_overflow, o_tx_flit, pkt(0));
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            set_pkt(k); i_valid = 1'b1;
            tick();
        end
        i_tx_ready = 1'b1; set_pkt(16);
        tick();
        checks++;
        if (o_overflow !== 1'b0 || o_tx_valid !== 1'b1 || o_tx_flit !== pkt(1)) begin
            errors++;
            $display("FAIL full_pushpop: ovf=%b v=%b flit=%h, want ovf=0 v=1 flit=%h",
                     o_overflow, o_tx_valid, o_tx_flit, pkt(1));
        end
        // Still full: a push with no pop must now be dropped.
        i_tx_ready = 1'b0; set_pkt(17);
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_count16: ovf=%b, want 1", o_overflow);
        end
        i_tx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_flit !== pkt(k)) begin
                errors++;
                $display("FAIL full_drain%0d: v=%b flit=%h, want v=1 flit=%h", k, o_tx_valid, o_tx_flit, pkt(k));
            end
            tick();
        end
        checks++;
        if (o_tx_valid !== 1'b0 || o_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_empty: v=%b empty=%b, want v=0 empty=1", o_tx_valid, o_empty);
        end
    endtask

    task automatic test_flush_drain();
        do_reset();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_pkt(k); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int k = 5; k < 7; k++) begin
            set_pkt(k); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0; i_tx_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_flit !== pkt(k) || o_tx_last !== (k == 4)) begin
                errors++;
                $display("FAIL flush_flit%0d: v=%b l=%b flit=%h, want v=1 l=%b flit=%h",
                         k, o_tx_valid, o_tx_last, o_tx_flit, k == 4, pkt(k));
            end
            tick();
        end
        checks++;
        if (o_empty !== 1'b1 || o_tx_last !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: empty=%b l=%b, want empty=1 l=0", o_empty, o_tx_last);
        end
    endtask

    task automatic test_null_flit();
        do_reset();
        i_tx_ready = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_last !== 1'b1 || o_tx_flit !== '0 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL null_start: v=%b l=%b flit=%h empty=%b, want v=1 l=1 flit=0 empty=0",
                     o_tx_valid, o_tx_last, o_tx_flit, o_empty);
        end
        set_pkt(3); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_last !== 1'b1 || o_tx_flit !== '0) begin
            errors++;
            $display("FAIL null_hold: v=%b l=%b flit=%h, want v=1 l=1 flit=0", o_tx_valid, o_tx_last, o_tx_flit);
        end
        i_tx_ready = 1'b1;
        tick();
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_last !== 1'b0 || o_tx_flit !== pkt(3)) begin
            errors++;
            $display("FAIL null_queued: v=%b l=%b flit=%h, want v=1 l=0 flit=%h",
                     o_tx_valid, o_tx_last, o_tx_flit, pkt(3));
        end
        tick();
        checks++;
        if (o_empty !== 1'b1 || o_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL null_idle: empty=%b v=%b, want empty=1 v=0", o_empty, o_tx_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_pkt(k); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_last !== 1'b0 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain: v=%b l=%b empty=%b, want v=1 l=0 empty=0", o_tx_valid, o_tx_last, o_empty);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({o_tx_valid, o_tx_last, o_empty, o_back_pressure, o_overflow} !== 5'b00100) begin
            errors++;
            $display("FAIL mid_reset: v/l/empty/bp/ovf=%b, want 00100",
                     {o_tx_valid, o_tx_last, o_empty, o_back_pressure, o_overflow});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pushpop();
        test_flush_drain();
        test_null_flit();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
